int8_mac_unit: RTL and testbench

Pipelined signed multiply-accumulate element: computes `accum_out = data_a * data_b + accum_in` on operands captured under an enable strobe. It is the arithmetic leaf of the transformer datapath's matrix/dot-product engines. The partial sum enters through `accum_in`, so the caller owns accumulation chaining. One result per enabled cycle, fixed two-edge latency, two's-complement wrap on overflow.

---
 rtl/int8_mac_unit_if.sv | 42 ++++
 rtl/int8_mac_unit.sv | 87 ++++++++
 tb/tb_int8_mac_unit.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/int8_mac_unit_if.sv
// int8_mac_unit_if
// Groups the operand/result signals of the MAC element into one bundle.
// Clock and reset stay outside as plain ports of the design.
//   en         : capture strobe, operands sampled on edges where it is high
//   data_a     : signed operand A
//   data_b     : signed operand B
//   accum_in   : signed partial sum to add to the product
//   accum_out  : signed registered result
//   out_valid  : one-cycle pulse marking a new accum_out value
// master drives operands (the caller), slave is the MAC element itself.
interface int8_mac_unit_if #(
  parameter int DATA_A_WIDTH = 8,
  parameter int DATA_B_WIDTH = 8,
  parameter int ACCUM_WIDTH  = 32
) ();

  logic                           en;
  logic signed [DATA_A_WIDTH-1:0] data_a;
  logic signed [DATA_B_WIDTH-1:0] data_b;
  logic signed [ACCUM_WIDTH-1:0]  accum_in;
  logic signed [ACCUM_WIDTH-1:0]  accum_out;
  logic                           out_valid;

  modport master (
    output en,
    output data_a,
    output data_b,
    output accum_in,
    input  accum_out,
    input  out_valid
  );

  modport slave (
    input  en,
    input  data_a,
    input  data_b,
    input  accum_in,
    output accum_out,
    output out_valid
  );

endinterface

// File: rtl/int8_mac_unit.sv
// int8_mac_unit
// Two-stage pipelined signed multiply-accumulate:
//   accum_out = sign_extend(data_a * data_b) + accum_in   (mod 2^ACCUM_WIDTH)
// Stage 1 captures the operands when en is high, stage 2 computes and
// registers the result one edge later. One result per enabled cycle.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset, clears every register
//   mac  : slave side of int8_mac_unit_if (en, data_a, data_b, accum_in,
//          accum_out, out_valid)
// ACCUM_WIDTH must be at least DATA_A_WIDTH + DATA_B_WIDTH so the full
// product fits before the add.
module int8_mac_unit #(
  parameter int DATA_A_WIDTH = 8,
  parameter int DATA_B_WIDTH = 8,
  parameter int ACCUM_WIDTH  = 32
) (
  input logic           clk,
  input logic           rst,
  int8_mac_unit_if.slave mac
);

  localparam int ProdWidth = DATA_A_WIDTH + DATA_B_WIDTH;

  // Stage-1 register names are kept as-is because they are observed by name.
  logic signed [DATA_A_WIDTH-1:0] data_a_reg;
  logic signed [DATA_B_WIDTH-1:0] data_b_reg;
  logic signed [ACCUM_WIDTH-1:0]  accum_in_reg;
  logic                           s1_valid;

  logic signed [ProdWidth-1:0]    product;
  logic signed [ACCUM_WIDTH-1:0]  productExt;
  logic signed [ACCUM_WIDTH-1:0]  sum;

  logic signed [ACCUM_WIDTH-1:0]  accum_out_q, accum_out_d;
  logic                           out_valid_q, out_valid_d;

  // Stage 1: capture operands on en; the operand registers hold when en is
  // low so only s1_valid needs to follow en every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_a_reg   <= '0;
      data_b_reg   <= '0;
      accum_in_reg <= '0;
      s1_valid     <= 1'b0;
    end else begin
      s1_valid <= mac.en;
      if (mac.en) begin
        data_a_reg   <= mac.data_a;
        data_b_reg   <= mac.data_b;
        accum_in_reg <= mac.accum_in;
      end
    end
  end

  // Full-width signed product, sign-extended before the wrapping add.
  always_comb begin
    product    = data_a_reg * data_b_reg;
    productExt = ACCUM_WIDTH'(product);
    sum        = productExt + accum_in_reg;
  end

  // Stage 2 next state: take the sum only when stage 1 holds a fresh
  // operand set, otherwise keep the previous result on the output.
  always_comb begin
    accum_out_d = accum_out_q;
    out_valid_d = s1_valid;
    if (s1_valid) begin
      accum_out_d = sum;
    end
  end

  // Stage 2 result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      accum_out_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      accum_out_q <= accum_out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign mac.accum_out = accum_out_q;
  assign mac.out_valid = out_valid_q;

endmodule

// File: tb/tb_int8_mac_unit.sv
// tb_int8_mac_unit
// Self-checking bench for int8_mac_unit. A driver issues directed operand
// sets and pushes the hand-computed result plus the cycle it should appear
// on into a queue; a monitor pops and compares whenever out_valid is high.
module tb_int8_mac_unit;

  localparam int AW = 8;
  localparam int BW = 8;
  localparam int CW = 32;

  typedef struct {
    logic signed [CW-1:0] value;
    int                   cycle;
    string                name;
  } expT;

  logic clk;
  logic rst;
  int   cycle;
  int   checks;
  int   errors;
  expT  expQ[$];

  int8_mac_unit_if #(.DATA_A_WIDTH(AW), .DATA_B_WIDTH(BW), .ACCUM_WIDTH(CW)) macIf ();

  int8_mac_unit #(.DATA_A_WIDTH(AW), .DATA_B_WIDTH(BW), .ACCUM_WIDTH(CW)) dut (
    .clk (clk),
    .rst (rst),
    .mac (macIf)
  );

  // Free-running clock and an edge counter used to time expected results.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkValue(input string name, input logic signed [CW-1:0] actual,
                            input logic signed [CW-1:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, required);
    end
  endtask

  task automatic checkOutput(input string name, input logic signed [CW-1:0] expAccum,
                             input logic expValid);
    checkValue({name, "_accum"}, macIf.accum_out, expAccum);
    checkValue({name, "_valid"}, CW'(macIf.out_valid), CW'(expValid));
  endtask

  // Drives one operand set with en high; called at a falling edge, so the
  // next rising edge captures it and the result appears one edge later.
  task automatic applyStimulus(input logic signed [AW-1:0] a, input logic signed [BW-1:0] b,
                               input logic signed [CW-1:0] acc, input logic signed [CW-1:0] expected,
                               input string name, input bit track);
    expT e;
    macIf.en       = 1'b1;
    macIf.data_a   = a;
    macIf.data_b   = b;
    macIf.accum_in = acc;
    if (track) begin
      e.value = expected;
      e.cycle = cycle + 2;
      e.name  = name;
      expQ.push_back(e);
    end
  endtask

  // Single pulse: capture edge, then idle for the remaining cycles and
  // confirm the result holds with out_valid low.
  task automatic singlePulse(input logic signed [AW-1:0] a, input logic signed [BW-1:0] b,
                             input logic signed [CW-1:0] acc, input logic signed [CW-1:0] expected,
                             input string name);
    applyStimulus(a, b, acc, expected, name, 1'b1);
    @(negedge clk);
    macIf.en = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput({name, "_hold"}, expected, 1'b0);
  endtask

  // Monitor: every valid result must match the head of the queue in both
  // value and arrival cycle; a valid with nothing expected is an error.
  always @(posedge clk) begin
    expT e;
    #1;
    if (macIf.out_valid === 1'b1) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_valid actual=%0d required=no result", macIf.accum_out);
      end else begin
        e = expQ.pop_front();
        checkValue(e.name, macIf.accum_out, e.value);
        checkValue({e.name, "_cycle"}, CW'(cycle), CW'(e.cycle));
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;

    // Reset with en high and random operands: everything must stay cleared.
    rst            = 1'b1;
    macIf.en       = 1'b1;
    macIf.data_a   = AW'($urandom);
    macIf.data_b   = BW'($urandom);
    macIf.accum_in = CW'($urandom);
    @(negedge clk);
    checkOutput("reset_first_edge", 0, 1'b0);
    macIf.data_a   = AW'($urandom);
    macIf.data_b   = BW'($urandom);
    macIf.accum_in = CW'($urandom);
    @(negedge clk);
    checkOutput("reset", 0, 1'b0);
    checkValue("reset_data_a_reg", CW'(dut.data_a_reg), 0);
    checkValue("reset_data_b_reg", CW'(dut.data_b_reg), 0);
    checkValue("reset_accum_in_reg", dut.accum_in_reg, 0);
    checkValue("reset_s1_valid", CW'(dut.s1_valid), 0);

    // First edge after reset release captures normally.
    rst = 1'b0;
    applyStimulus(5, 3, 10, 25, "basic_5x3p10", 1'b1);
    @(negedge clk);
    macIf.en = 1'b0;
    checkValue("s1_data_a_reg", CW'(dut.data_a_reg), 5);
    checkValue("s1_data_b_reg", CW'(dut.data_b_reg), 3);
    checkValue("s1_accum_in_reg", dut.accum_in_reg, 10);
    repeat (3) @(negedge clk);
    checkOutput("basic_5x3p10_hold", 25, 1'b0);

    singlePulse(-4, 6, 25, 1, "neg_m4x6p25");
    singlePulse(0, 10, 50, 50, "zero_0x10p50");
    singlePulse(127, 127, 0, 16129, "max_127x127");
    singlePulse(-128, -128, 0, 16384, "min_m128xm128");
    singlePulse(-128, 127, -5, -16261, "mixed_m128x127m5");
    singlePulse(1, 1, 32'sh7FFF_FFFF, 32'sh8000_0000, "wrap_max");

    // Back-to-back captures give back-to-back results in order.
    applyStimulus(2, 3, 1, 7, "pipe_0", 1'b1);
    @(negedge clk);
    applyStimulus(-1, -1, 0, 1, "pipe_1", 1'b1);
    @(negedge clk);
    applyStimulus(7, -2, 100, 86, "pipe_2", 1'b1);
    @(negedge clk);
    macIf.en = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("pipe_hold", 86, 1'b0);

    // Reset right after a capture discards the in-flight operand.
    applyStimulus(9, 9, 0, 81, "flight_9x9", 1'b0);
    @(negedge clk);
    macIf.en = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("flight_reset", 0, 1'b0);
    repeat (4) @(negedge clk);
    checkOutput("flight_after", 0, 1'b0);

    checkValue("queue_drained", CW'(expQ.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
